// File: rtl/adc_slice_capture.sv
// adc_slice_capture: emulator-side consumer of one stochastic ADC slice.
// Detects rising edges of the slice's clk_adder (sampled as data on emu_clk),
// converts the sign/magnitude sample to two's complement, tags it with a
// running index and queues it in a small first-word-fall-through FIFO.
// Optional feature macro: ADC_CAPTURE_STATS_EN builds the saturating drop counter;
// without it drop_count is tied to zero.
module adc_slice_capture #(
  parameter int Nadc  = 8,
  parameter int DEPTH = 4,
  parameter int SKIP  = 2,
  parameter int Nidx  = 16
) (
  input  logic                   emu_clk,
  input  logic                   emu_rst,
  input  logic                   clk_adder,
  input  logic                   en_sync,
  input  logic                   sign_in,
  input  logic [Nadc-1:0]        mag_in,
  output logic [Nadc:0]          out_data,
  output logic [Nidx-1:0]        out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf,
  input  logic                   clear_ovf,
  output logic [Nidx-1:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  // Skip counter needs at least one bit even when SKIP is 0 or 1.
  localparam int SW = (SKIP < 2) ? 1 : $clog2(SKIP + 1);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} state_t;

  state_t          r_state;
  logic            r_clk_adder_d;
  logic [SW-1:0]   r_skip_cnt;
  logic [Nidx-1:0] r_index;
  logic [Nadc:0]   r_mem_data  [DEPTH];
  logic [Nidx-1:0] r_mem_index [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [Nadc:0]   r_hold_data;
  logic [Nidx-1:0] r_hold_index;
  logic            r_ovf;

  logic            w_rise;
  logic            w_skip_done;
  logic            w_push_req;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [Nadc:0]   w_mag_ext;
  logic [Nadc:0]   w_sample;

  assign w_rise      = clk_adder & ~r_clk_adder_d;
  assign w_mag_ext   = {1'b0, mag_in};
  // Negating a zero magnitude yields zero, so both signs of 0 map to 0.
  assign w_sample    = sign_in ? w_mag_ext : ((Nadc+1)'(0) - w_mag_ext);
  assign w_skip_done = (({1'b0, r_skip_cnt} + (SW+1)'(1)) == (SW+1)'(SKIP));
  // A rise in the same cycle that en_sync drops is ignored.
  assign w_push_req  = (r_state == S_RUN) & en_sync & w_rise;

  assign w_full      = (r_level == (AW+1)'(DEPTH));
  assign out_valid   = (r_level != '0);
  assign w_pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop;

  // Head of the FIFO when non-empty, otherwise the most recently popped sample.
  assign out_data    = out_valid ? r_mem_data[r_rd_ptr]  : r_hold_data;
  assign out_index   = out_valid ? r_mem_index[r_rd_ptr] : r_hold_index;
  assign fifo_level  = r_level;
  assign ovf         = r_ovf;

  // Slice synchronisation FSM, clk_adder edge history and running sample index.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      r_state       <= S_IDLE;
      r_clk_adder_d <= 1'b0;
      r_skip_cnt    <= '0;
      r_index       <= '0;
    end else begin
      r_clk_adder_d <= clk_adder;
      case (r_state)
        S_IDLE: begin
          r_skip_cnt <= '0;
          if (en_sync) begin
            r_index <= '0;
            r_state <= (SKIP == 0) ? S_RUN : S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (!en_sync) begin
            r_state <= S_IDLE;
          end else if (w_rise) begin
            // The rise that completes the settling count is itself discarded.
            if (w_skip_done) begin
              r_state <= S_RUN;
              r_index <= '0;
            end else begin
              r_skip_cnt <= r_skip_cnt + SW'(1);
            end
          end
        end
        S_RUN: begin
          if (!en_sync) begin
            r_state <= S_IDLE;
          end else if (w_rise) begin
            // Index advances on every capture, including dropped ones.
            r_index <= r_index + Nidx'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage: only the tail entry is written, contents need no reset.
  always_ff @(posedge emu_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= w_sample;
      r_mem_index[r_wr_ptr] <= r_index;
    end
  end

  // FIFO pointers, occupancy and the hold register for the last popped sample.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_hold_data  <= '0;
      r_hold_index <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_hold_data  <= r_mem_data[r_rd_ptr];
        r_hold_index <= r_mem_index[r_rd_ptr];
      end
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Sticky overflow flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef ADC_CAPTURE_STATS_EN
  logic [Nidx-1:0] r_drop_count;

  // Saturating drop counter; clearing and dropping together leaves a count of one.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      r_drop_count <= '0;
    end else if (clear_ovf) begin
      r_drop_count <= w_drop ? Nidx'(1) : '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + Nidx'(1);
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_adc_slice_capture.sv
// Testbench for adc_slice_capture: directed scenarios plus randomized traffic.
// A reference model updates on each emu_clk rise and pushes expected samples
// into a scoreboard; a separate monitor compares on the falling edge.
module tb_adc_slice_capture;

  localparam int NADC  = 8;
  localparam int DEPTH = 4;
  localparam int SKIP  = 2;
  localparam int NIDX  = 4;
`ifdef ADC_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   emu_clk   = 1'b0;
  logic                   emu_rst   = 1'b1;
  logic                   clk_adder = 1'b0;
  logic                   en_sync   = 1'b0;
  logic                   sign_in   = 1'b0;
  logic [NADC-1:0]        mag_in    = '0;
  logic                   out_ready = 1'b0;
  logic                   clear_ovf = 1'b0;
  logic [NADC:0]          out_data;
  logic [NIDX-1:0]        out_index;
  logic                   out_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   ovf;
  logic [NIDX-1:0]        drop_count;

  adc_slice_capture #(.Nadc(NADC), .DEPTH(DEPTH), .SKIP(SKIP), .Nidx(NIDX)) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .clk_adder (clk_adder),
    .en_sync   (en_sync),
    .sign_in   (sign_in),
    .mag_in    (mag_in),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_level(fifo_level),
    .ovf       (ovf),
    .clear_ovf (clear_ovf),
    .drop_count(drop_count)
  );

  always #5 emu_clk = ~emu_clk;

  typedef struct {
    int data;
    int idx;
  } sample_t;

  sample_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (phase: 0 idle, 1 settling, 2 capturing)
  int m_phase = 0;
  int m_skipped = 0;
  int m_idx = 0;
  int m_cnt = 0;
  int m_drops = 0;
  bit m_prev = 1'b0;
  bit m_ovf = 1'b0;
  bit m_live = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Behavioural model of one emu_clk edge, evaluated on the pre-edge inputs.
  task automatic model_step();
    bit rise, pop, push, acc, drop;
    sample_t s;
    if (emu_rst) begin
      m_phase = 0; m_skipped = 0; m_idx = 0; m_cnt = 0; m_drops = 0;
      m_prev = 1'b0; m_ovf = 1'b0; m_live = 1'b1;
      sb_q.delete();
      return;
    end
    rise = clk_adder && !m_prev;
    m_prev = clk_adder;
    pop = (m_cnt > 0) && out_ready;
    push = 0; acc = 0; drop = 0;
    case (m_phase)
      0: if (en_sync) begin
        m_skipped = 0;
        m_idx = 0;
        m_phase = (SKIP == 0) ? 2 : 1;
      end
      1: if (!en_sync) m_phase = 0;
         else if (rise) begin
           m_skipped++;
           if (m_skipped == SKIP) begin
             m_phase = 2;
             m_idx = 0;
           end
         end
      2: if (!en_sync) m_phase = 0;
         else if (rise) push = 1;
      default: m_phase = 0;
    endcase
    if (push) begin
      if (m_cnt - int'(pop) < DEPTH) begin
        acc = 1;
        s.data = sign_in ? int'(mag_in) : -int'(mag_in);
        s.idx = m_idx;
        sb_q.push_back(s);
      end else begin
        drop = 1;
      end
      m_idx = (m_idx + 1) % (1 << NIDX);
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    if (clear_ovf) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < (1 << NIDX) - 1) m_drops++;
    m_cnt = m_cnt - int'(pop) + int'(acc);
  endtask

  initial begin
    forever begin
      @(posedge emu_clk);
      model_step();
    end
  end

  // Monitor: compares DUT against the model and pops the scoreboard on handshakes.
  initial begin
    int last_d = 0;
    int last_i = 0;
    sample_t s;
    forever begin
      @(negedge emu_clk);
      if (!m_live) continue;
      check("out_valid", out_valid, m_cnt > 0);
      check("fifo_level", fifo_level, m_cnt);
      check("ovf", ovf, m_ovf);
      check("drop_count", drop_count, STATS ? m_drops : 0);
      if (out_valid !== 1'b1) begin
        check("hold_data", $signed(out_data), last_d);
        check("hold_index", out_index, last_i);
      end else if (out_ready && !emu_rst) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got data %0d idx %0d, expected no sample",
                   $signed(out_data), out_index);
        end else begin
          s = sb_q.pop_front();
          check("pop_data", $signed(out_data), s.data);
          check("pop_index", out_index, s.idx);
          $display("pop  idx=%0d data=%0d (model idx=%0d data=%0d)",
                   out_index, $signed(out_data), s.idx, s.data);
        end
      end
      if (emu_rst) begin
        last_d = 0;
        last_i = 0;
      end else if (out_valid === 1'b1 && out_ready) begin
        last_d = s.data;
        last_i = s.idx;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge emu_clk);
      #1;
    end
  endtask

  task automatic adc_edge(bit s, int m, int half);
    sign_in = s;
    mag_in = NADC'(m);
    clk_adder = 1'b1;
    cyc(half);
    clk_adder = 1'b0;
    cyc(half);
  endtask

  task automatic rnd_edges(int n);
    for (int i = 0; i < n; i++) adc_edge(1'($urandom), int'($urandom_range(0, 255)), 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and basic conversion
    @(posedge emu_clk); #1;
    cyc(3);
    emu_rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_data", out_data, 0);
    en_sync = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    adc_edge(1, 77, 4);
    adc_edge(0, 33, 4);
    adc_edge(1, 10, 4);
    adc_edge(0, 10, 4);
    adc_edge(1, 255, 4);
    adc_edge(0, 0, 4);

    // Overflow: six captures with a stalled consumer
    out_ready = 1'b0;
    rnd_edges(6);
    check("full_level", fifo_level, DEPTH);
    check("full_ovf", ovf, 1);
    out_ready = 1'b1;
    cyc(8);
    adc_edge(1, 5, 4);

    // Push accepted while full because the head pops in the same cycle
    clear_ovf = 1'b1;
    cyc(1);
    clear_ovf = 1'b0;
    out_ready = 1'b0;
    rnd_edges(4);
    sign_in = 1'b0;
    mag_in = 8'd99;
    out_ready = 1'b1;
    clk_adder = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    check("swap_level", fifo_level, DEPTH);
    check("swap_ovf", ovf, 0);
    clk_adder = 1'b0;
    cyc(3);
    // Drop coinciding with clear_ovf
    clear_ovf = 1'b1;
    clk_adder = 1'b1;
    cyc(1);
    clear_ovf = 1'b0;
    check("drop_clear_ovf", ovf, 1);
    check("drop_clear_cnt", drop_count, STATS ? 1 : 0);
    clk_adder = 1'b0;
    cyc(3);
    out_ready = 1'b1;
    cyc(8);

    // en_sync drop mid-capture: queued entries drain, resync restarts index
    out_ready = 1'b0;
    rnd_edges(3);
    en_sync = 1'b0;
    rnd_edges(2);
    check("desync_level", fifo_level, 3);
    out_ready = 1'b1;
    cyc(6);
    check("desync_drained", fifo_level, 0);
    en_sync = 1'b1;
    cyc(1);
    rnd_edges(4);

    // Reset with a full FIFO and ovf set
    out_ready = 1'b0;
    rnd_edges(6);
    emu_rst = 1'b1;
    cyc(1);
    emu_rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovf", ovf, 0);

    // Index wrap: two settling rises then 17 captures
    out_ready = 1'b1;
    cyc(1);
    rnd_edges(SKIP + 17);
    cyc(4);

    // Randomized traffic, including single-cycle clk_adder pulses
    for (int i = 0; i < 3000; i++) begin
      clk_adder = ($urandom_range(0, 2) == 0) ? ~clk_adder : clk_adder;
      sign_in = 1'($urandom);
      case ($urandom_range(0, 5))
        0: mag_in = '0;
        1: mag_in = '1;
        default: mag_in = NADC'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      clear_ovf = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 250) == 0) en_sync = ~en_sync;
      else if (!en_sync && $urandom_range(0, 20) == 0) en_sync = 1'b1;
      cyc(1);
    end
    clear_ovf = 1'b0;
    clk_adder = 1'b0;
    out_ready = 1'b1;
    cyc(10);
    check("final_empty", fifo_level, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_slice_capture.md
Name: adc_slice_capture

Overview:
Emulator-side consumer of one stochastic ADC slice output. Runs on the emulator clock and detects rising edges of the slice's clk_adder. On each edge it captures the slice's sign/magnitude pair and converts it to two's complement. Each sample is tagged with a sample index and buffered in a small first-word-fall-through FIFO with a valid/ready output to the downstream DSP/JTAG capture logic. Capture starts only after slice synchronization (en_sync_out) and a settling skip.

Parameters:
Nadc, 8, magnitude width from the slice
DEPTH, 4, FIFO entries; must be a power of 2, at least 2
SKIP, 2, clk_adder rising edges discarded after sync before capture starts
Nidx, 16, sample index width

Ports:
emu_clk  input  1  emulator clock; sole clock of the block
emu_rst  input  1  reset, synchronous, active-high
clk_adder  input  1  slice output clock, sampled as data in the emu_clk domain
en_sync  input  1  slice en_sync_out; level
sign_in  input  1  slice sign_out; 1 = positive, 0 = negative
mag_in  input  Nadc  slice adder_out magnitude
out_data  output  Nadc+1  signed sample at FIFO head
out_index  output  Nidx  index of the head sample
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts the head sample
fifo_level  output  log2(DEPTH)+1  current occupancy
ovf  output  1  sticky: at least one sample dropped because the FIFO was full
clear_ovf  input  1  clears ovf (and drop_count when the optional feature is built)
drop_count  output  Nidx  saturating drop counter (optional feature)

Behaviour:
- Reset (emu_rst=1 at an emu_clk edge): state=IDLE, FIFO empty, out_valid=0, out_data=0, out_index=0, fifo_level=0, ovf=0, drop_count=0, clk_adder_d=0, skip counter=0, index=0. Reset mid-operation discards FIFO contents.
- Edge detect: clk_adder_d is registered every cycle. rise = clk_adder & ~clk_adder_d. A clk_adder that is high out of reset produces one rise on the first cycle.
- Capture on the rise cycle uses the current sign_in/mag_in values. Conversion: data = sign_in ? +mag : -mag, sign-extended to Nadc+1. mag=0 gives 0 for either sign. mag=255 gives +255 or -255 (9'h101).
- FSM:
  - IDLE: go to ALIGN when en_sync=1; clear the skip counter.
  - ALIGN: each rise increments the skip counter. The rise that makes the count equal SKIP is itself discarded, sets index=0, and moves to RUN. With SKIP=0, go to RUN directly with index=0.
  - RUN: each rise produces a push request with (data, index), then index increments, wrapping from 2^Nidx-1 to 0.
  - From ALIGN or RUN, en_sync=0 returns to IDLE on the next edge. A rise in that same cycle is ignored. FIFO contents are retained and continue to drain.
- FIFO:
  - A pop occurs when out_valid & out_ready.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Simultaneous push and pop when empty: no pop; the push is accepted.
  - A push refused because the FIFO is full is a drop: the index still increments and ovf sets.
  - Latency: clk_adder high sampled at cycle N gives out_valid=1 with the sample in cycle N+1.
- ovf: set on a drop and cleared by clear_ovf. If a drop and clear_ovf occur in the same cycle, set wins.
- fifo_level is exact each cycle: 0..DEPTH.
- out_data and out_index hold the last popped values when the FIFO is empty.

Optional Feature:
ADC_CAPTURE_STATS_EN
- Defined: drop_count increments on each drop and saturates at 2^Nidx-1. clear_ovf zeroes it; a drop in the same cycle as clear_ovf gives 1.
- Undefined: the drop_count port exists but is tied to 0, and no counter logic is built.

Test Plan:
- Reset, en_sync=1, toggle clk_adder every 4 emu_clk, sign/mag = 1/10, 0/10, 1/255, 0/0, out_ready=1. The first 2 rises are skipped. Outputs are data +10, -10, +255, 0 with index 0, 1, 2, 3, each with out_valid high one cycle after the rise is sampled.
- out_ready=0 for 6 rises in RUN with DEPTH=4: fifo_level reaches 4 and ovf=1. Then set out_ready=1: entries drain with index 0..3, index 4..5 are lost, and the next sample has index 6.
- FIFO full, and a rise coincides with out_ready=1: the push is accepted, fifo_level stays at 4, ovf stays 0. A drop in the same cycle as clear_ovf leaves ovf=1. With ADC_CAPTURE_STATS_EN, drop_count=1.
- Drop en_sync mid-RUN with 3 entries queued: no further pushes. All 3 entries drain. Re-assert en_sync: after 2 skipped rises, index restarts at 0.
- Assert emu_rst with 2 entries queued and state=RUN: the next cycle shows out_valid=0, fifo_level=0, ovf=0, state=IDLE.
- Index wrap with Nidx=4: 17 consecutive captures with out_ready=1 give indices 0..15 then 0.
